// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NREQ requesters.
// Owners get bursts of up to MAXBURST words; wfull stalls the burst without losing it.
module fifo_wr_arbiter #(
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXBURST = 4,
   parameter int unsigned IDW      = 2
) (
   input  logic                  wclk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   input  logic                  wfull,
   output logic [DSIZE-1:0]      wdata,
   output logic                  winc,
   output logic                  busy,
   output logic [IDW-1:0]        owner
);

   localparam int unsigned BW = $clog2(MAXBURST + 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic [IDW-1:0]   pick;
   logic [IDW-1:0]   cand;
   logic             found;
   logic             xfer;
   logic [DSIZE-1:0] slice [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign slice[g] = req_data[g*DSIZE +: DSIZE];
   end

   // Scan starts one past the last owner; the owner itself is the last candidate.
   always_comb begin
      pick  = owner_q;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         cand = IDW'((32'(owner_q) + 32'(k)) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign xfer  = (state_q == StGrant) & req[owner_q] & ~wfull;
   assign winc  = xfer;
   assign busy  = (state_q == StGrant);
   assign owner = owner_q;

   always_comb begin
      gnt   = '0;
      wdata = '0;
      if (xfer) begin
         gnt[owner_q] = 1'b1;
         wdata        = slice[owner_q];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               owner_d = pick;
               bcnt_d  = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (!req[owner_q]) begin
               state_d = StIdle;
            end else if (xfer) begin
               bcnt_d = bcnt_q + BW'(1);
               if (bcnt_d == BW'(MAXBURST)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         owner_q <= IDW'(NREQ - 1);
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule
